// File: rtl/door_exit_ctrl.sv
// door_exit_ctrl: sequences the two level-exit doors.
// The per-door animation frames follow the player-overlap flags. The level is
// declared done once both doors are fully open and both players have held on
// them for HOLD_FRAMES ticks.
// Optional build macro DOOR_KEY_EN adds the key_ok input. When key_ok is low,
// the doors may not open and the hold phase cannot start or continue.
module door_exit_ctrl #(
    parameter int ANIM_DIV    = 4,
    parameter int OPEN_FRAMES = 8,
    parameter int HOLD_FRAMES = 30
) (
    input  logic                           frame_clk,
    input  logic                           RESET,
    input  logic [1:0]                     reach,
`ifdef DOOR_KEY_EN
    input  logic                           key_ok,
`endif
    input  logic                           next_level,
    output logic [$clog2(OPEN_FRAMES)-1:0] door_frame0,
    output logic [$clog2(OPEN_FRAMES)-1:0] door_frame1,
    output logic [1:0]                     door_open,
    output logic                           exiting,
    output logic                           level_done
);

    localparam int FW = $clog2(OPEN_FRAMES);
    localparam int DW = $clog2(ANIM_DIV + 1);
    localparam int HW = $clog2(HOLD_FRAMES + 1);

    localparam logic [FW-1:0] FRAME_MAX = FW'(OPEN_FRAMES - 1);
    localparam logic [DW-1:0] DIV_MAX   = DW'(ANIM_DIV - 1);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(HOLD_FRAMES - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HOLD   = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [FW-1:0] frame0_q, frame0_d;
    logic [FW-1:0] frame1_q, frame1_d;
    logic [DW-1:0] div_q, div_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [1:0]    door_open_q, door_open_d;
    logic          exiting_q, exiting_d;
    logic          level_done_q, level_done_d;

    logic          key_s;
    logic          step_s;
    logic          both_s;
    logic [DW-1:0] div_next_s;

`ifdef DOOR_KEY_EN
    assign key_s = key_ok;
`else
    assign key_s = 1'b1;
`endif

    assign step_s     = (div_q == DIV_MAX);
    assign div_next_s = step_s ? {DW{1'b0}} : (div_q + DW'(1));
    assign both_s     = (reach == 2'b11) && key_s;

    // Opening is gated by key availability; closing never is.
    // Both ends saturate, so the frame never wraps.
    function automatic logic [FW-1:0] anim_step(input logic [FW-1:0] frame,
                                                input logic          near,
                                                input logic          key,
                                                input logic          step);
        logic [FW-1:0] res;
        res = frame;
        if (step) begin
            if (near) begin
                if (key && (frame != FRAME_MAX)) begin
                    res = frame + FW'(1);
                end else begin
                    res = frame;
                end
            end else if (frame != {FW{1'b0}}) begin
                res = frame - FW'(1);
            end else begin
                res = frame;
            end
        end else begin
            res = frame;
        end
        return res;
    endfunction

    // Next-state, counters and output decode for the door sequencer
    always_comb begin
        state_d  = state_q;
        frame0_d = frame0_q;
        frame1_d = frame1_q;
        div_d    = div_q;
        hold_d   = hold_q;
        case (state_q)
            ST_IDLE: begin
                div_d    = div_next_s;
                frame0_d = anim_step(frame0_q, reach[0], key_s, step_s);
                frame1_d = anim_step(frame1_q, reach[1], key_s, step_s);
                hold_d   = {HW{1'b0}};
                if ((door_open_q == 2'b11) && both_s) begin
                    state_d = ST_HOLD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_HOLD: begin
                div_d    = div_next_s;
                frame0_d = anim_step(frame0_q, reach[0], key_s, step_s);
                frame1_d = anim_step(frame1_q, reach[1], key_s, step_s);
                if (!both_s) begin
                    state_d = ST_IDLE;
                    hold_d  = {HW{1'b0}};
                end else if (hold_q == HOLD_MAX) begin
                    state_d = ST_LOCKED;
                    hold_d  = hold_q;
                end else begin
                    state_d = ST_HOLD;
                    hold_d  = hold_q + HW'(1);
                end
            end
            ST_LOCKED: begin
                // Doors stay fully open and reach is ignored until rearmed.
                if (next_level) begin
                    state_d  = ST_IDLE;
                    frame0_d = {FW{1'b0}};
                    frame1_d = {FW{1'b0}};
                    div_d    = {DW{1'b0}};
                    hold_d   = {HW{1'b0}};
                end else begin
                    state_d  = ST_LOCKED;
                    frame0_d = FRAME_MAX;
                    frame1_d = FRAME_MAX;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                frame0_d = {FW{1'b0}};
                frame1_d = {FW{1'b0}};
                div_d    = {DW{1'b0}};
                hold_d   = {HW{1'b0}};
            end
        endcase
        door_open_d  = {(frame1_d == FRAME_MAX), (frame0_d == FRAME_MAX)};
        exiting_d    = (state_d == ST_HOLD);
        level_done_d = (state_q == ST_HOLD) && (state_d == ST_LOCKED);
    end

    // State, counters and registered outputs
    always_ff @(posedge frame_clk or posedge RESET) begin
        if (RESET) begin
            state_q      <= ST_IDLE;
            frame0_q     <= {FW{1'b0}};
            frame1_q     <= {FW{1'b0}};
            div_q        <= {DW{1'b0}};
            hold_q       <= {HW{1'b0}};
            door_open_q  <= 2'b00;
            exiting_q    <= 1'b0;
            level_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            frame0_q     <= frame0_d;
            frame1_q     <= frame1_d;
            div_q        <= div_d;
            hold_q       <= hold_d;
            door_open_q  <= door_open_d;
            exiting_q    <= exiting_d;
            level_done_q <= level_done_d;
        end
    end

    assign door_frame0 = frame0_q;
    assign door_frame1 = frame1_q;
    assign door_open   = door_open_q;
    assign exiting     = exiting_q;
    assign level_done  = level_done_q;

endmodule

// File: tb/tb_door_exit_ctrl.sv
// Self-checking bench for door_exit_ctrl.
// It combines directed scenarios with randomized reach runs, and compares the
// DUT against a behavioural model of the door rules.
module tb_door_exit_ctrl;

    localparam int ANIM_DIV    = 4;
    localparam int OPEN_FRAMES = 8;
    localparam int HOLD_FRAMES = 30;
    localparam int FMAX        = OPEN_FRAMES - 1;

    logic       frame_clk;
    logic       RESET;
    logic [1:0] reach;
    logic       next_level;
    logic [2:0] door_frame0;
    logic [2:0] door_frame1;
    logic [1:0] door_open;
    logic       exiting;
    logic       level_done;

    int tests;
    int fails;

    // Model state: door frames, divider count, hold progress and phase flags
    int m_frame[2];
    int m_div;
    int m_hold;
    bit m_holding;
    bit m_locked;
    bit m_done;

    door_exit_ctrl #(
        .ANIM_DIV   (ANIM_DIV),
        .OPEN_FRAMES(OPEN_FRAMES),
        .HOLD_FRAMES(HOLD_FRAMES)
    ) dut (
        .frame_clk  (frame_clk),
        .RESET      (RESET),
        .reach      (reach),
`ifdef DOOR_KEY_EN
        .key_ok     (1'b1),
`endif
        .next_level (next_level),
        .door_frame0(door_frame0),
        .door_frame1(door_frame1),
        .door_open  (door_open),
        .exiting    (exiting),
        .level_done (level_done)
    );

    initial frame_clk = 1'b0;
    always #5 frame_clk = ~frame_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_frame[0] = 0;
        m_frame[1] = 0;
        m_div      = 0;
        m_hold     = 0;
        m_holding  = 1'b0;
        m_locked   = 1'b0;
        m_done     = 1'b0;
    endtask

    // One frame tick of the door rules, using pre-tick values throughout
    task automatic model_step(input logic [1:0] r, input logic nl);
        bit both_open;
        bit both_reach;
        bit step;
        m_done = 1'b0;
        if (m_locked) begin
            if (nl) begin
                m_locked   = 1'b0;
                m_frame[0] = 0;
                m_frame[1] = 0;
                m_div      = 0;
                m_hold     = 0;
            end
        end else begin
            both_open  = (m_frame[0] == FMAX) && (m_frame[1] == FMAX);
            both_reach = (r == 2'b11);
            step       = (m_div == ANIM_DIV - 1);
            m_div      = (m_div + 1) % ANIM_DIV;
            if (m_holding) begin
                if (!both_reach) begin
                    m_holding = 1'b0;
                    m_hold    = 0;
                end else if (m_hold == HOLD_FRAMES - 1) begin
                    m_holding = 1'b0;
                    m_locked  = 1'b1;
                    m_done    = 1'b1;
                end else begin
                    m_hold++;
                end
            end else if (both_open && both_reach) begin
                m_holding = 1'b1;
                m_hold    = 0;
            end
            if (step) begin
                for (int i = 0; i < 2; i++) begin
                    if (r[i] && m_frame[i] < FMAX) m_frame[i]++;
                    else if (!r[i] && m_frame[i] > 0) m_frame[i]--;
                end
            end
        end
    endtask

    task automatic check_all();
        chk("door_frame0", 32'(door_frame0), 32'(m_frame[0]));
        chk("door_frame1", 32'(door_frame1), 32'(m_frame[1]));
        chk("door_open", 32'(door_open),
            32'({(m_frame[1] == FMAX), (m_frame[0] == FMAX)}));
        chk("exiting", 32'(exiting), 32'(m_holding));
        chk("level_done", 32'(level_done), 32'(m_done));
    endtask

    // Drive at the falling edge, step the model at the rising edge,
    // then compare at the next falling edge.
    task automatic tick(input logic [1:0] r, input logic nl);
        reach      = r;
        next_level = nl;
        @(posedge frame_clk);
        model_step(r, nl);
        @(negedge frame_clk);
        check_all();
        next_level = 1'b0;
    endtask

    initial begin
        int  cnt;
        int  entry_idx;
        int  done_idx;
        bit  seen;
        logic [1:0] rr;
        int  run;

        tests      = 0;
        fails      = 0;
        RESET      = 1'b1;
        reach      = 2'b00;
        next_level = 1'b0;
        model_reset();
        repeat (3) @(negedge frame_clk);
        check_all();
        RESET = 1'b0;

        // 1: idle with nobody at the doors
        for (int i = 0; i < 100; i++) tick(2'b00, 1'b0);

        // 2: door 0 opens and saturates, then closes fully
        for (int i = 0; i < 32; i++) tick(2'b01, 1'b0);
        chk("door0_open_sat", 32'(door_frame0), 32'(FMAX));
        chk("door1_stays_closed", 32'(door_frame1), 32'd0);
        for (int i = 0; i < 32; i++) tick(2'b00, 1'b0);
        chk("door0_closed", 32'(door_frame0), 32'd0);

        // 3: both players hold until the level completes
        entry_idx = -1;
        done_idx  = -1;
        for (int i = 0; i < 200 && done_idx < 0; i++) begin
            tick(2'b11, 1'b0);
            if (exiting === 1'b1 && entry_idx < 0) entry_idx = i;
            if (level_done === 1'b1) done_idx = i;
        end
        chk("hold_to_done_latency", 32'(done_idx - entry_idx), 32'(HOLD_FRAMES));
        tick(2'b11, 1'b0);
        chk("level_done_one_tick", 32'(level_done), 32'd0);
        for (int i = 0; i < 12; i++) tick(2'b00, 1'b0);
        chk("locked_frames_frozen", 32'(door_frame0), 32'(FMAX));

        // 5: rearm from LOCKED
        tick(2'b00, 1'b1);
        chk("rearm_frame0", 32'(door_frame0), 32'd0);
        chk("rearm_open", 32'(door_open), 32'd0);

        // 5: next_level while idle has no effect
        for (int i = 0; i < 10; i++) tick(2'b01, 1'b0);
        tick(2'b01, 1'b1);
        tick(2'b01, 1'b0);

        // 4: brief drop of door 1 in the middle of a hold
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            tick(2'b11, 1'b0);
            seen = (exiting === 1'b1);
        end
        chk("hold_entered", 32'(seen), 32'd1);
        for (int i = 0; i < 15; i++) tick(2'b11, 1'b0);
        tick(2'b01, 1'b0);
        chk("drop_exits_hold", 32'(exiting), 32'd0);
        cnt  = 0;
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            tick(2'b11, 1'b0);
            cnt++;
            seen = (level_done === 1'b1);
        end
        chk("restart_done_seen", 32'(seen), 32'd1);
        chk("no_done_at_old_deadline", 32'(cnt > HOLD_FRAMES - 16), 32'd1);
        tick(2'b10, 1'b1);

        // Randomized runs of reach patterns with occasional rearm pulses
        cnt = 0;
        while (cnt < 900) begin
            rr  = (($urandom_range(0, 9) < 6) ? 2'b11 : 2'($urandom_range(0, 3)));
            run = $urandom_range(1, 45);
            for (int i = 0; i < run; i++) begin
                tick(rr, ($urandom_range(0, 15) == 0));
                cnt++;
            end
        end
        tick(2'b00, 1'b1);

        // 6: asynchronous reset in the middle of a hold
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            tick(2'b11, 1'b0);
            seen = (exiting === 1'b1);
        end
        chk("hold_entered_2", 32'(seen), 32'd1);
        for (int i = 0; i < 10; i++) tick(2'b11, 1'b0);
        #2;
        RESET = 1'b1;
        #1;
        chk("async_frame0", 32'(door_frame0), 32'd0);
        chk("async_frame1", 32'(door_frame1), 32'd0);
        chk("async_open", 32'(door_open), 32'd0);
        chk("async_exiting", 32'(exiting), 32'd0);
        chk("async_done", 32'(level_done), 32'd0);
        model_reset();
        @(posedge frame_clk);
        @(negedge frame_clk);
        check_all();
        RESET = 1'b0;
        for (int i = 0; i < 40; i++) tick(2'b11, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
